// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-requester arbiter between L1 cache ports and a single L2 line interface.
// One line transfer is in flight at a time. The winner's op, address and write line are
// registered at the grant edge. A one-cycle req_resp pulse goes back to the granted port.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   req_read/req_write [N]           per-port level requests, held until req_resp
//   req_address/req_wdata            per-port packed address / write line (port i at i*W)
//   req_resp [N], req_rdata          one-hot completion pulse, registered read line
//   mem_read/mem_write               downstream request, held until mem_resp
//   mem_address/mem_wdata            registered granted address / write line
//   mem_resp, mem_rdata              downstream completion pulse and read line
module mem_arbiter_n #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 256,
    parameter bit          RR_MODE    = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [LINE_WIDTH-1:0]            mem_wdata,
    input  logic                             mem_resp,
    input  logic [LINE_WIDTH-1:0]            mem_rdata
);

    localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        grant_q, grant_d;
    logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                   write_q, write_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0]  rdata_q, rdata_d;

    logic [NUM_PORTS-1:0]   req_any;
    logic                   win_valid;
    logic [IdxW-1:0]        win_idx;
    int unsigned            cand;
    int unsigned            next_ptr;

    assign req_any = req_read | req_write;

    // Winner search: in round-robin mode the scan starts at rr_ptr and wraps; in fixed
    // mode it starts at port 0. The first requesting port in scan order wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = (RR_MODE ? 32'(rr_ptr_q) + k : k) % NUM_PORTS;
            if (!win_valid && req_any[cand[IdxW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[IdxW-1:0];
            end
        end
        next_ptr = (32'(win_idx) + 1) % NUM_PORTS;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    grant_d  = win_idx;
                    rr_ptr_d = next_ptr[IdxW-1:0];
                    // A port raising both read and write is serviced as a write.
                    write_d  = req_write[win_idx];
                    addr_d   = req_address[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d  = req_wdata[win_idx*LINE_WIDTH +: LINE_WIDTH];
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (mem_resp) begin
                    if (!write_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs are registers or decodes of registered state only.
    assign mem_read    = (state_q == StBusy) && !write_q;
    assign mem_write   = (state_q == StBusy) && write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign req_rdata   = rdata_q;

    always_comb begin
        req_resp = '0;
        if (state_q == StDone) begin
            req_resp[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
module tb_mem_arbiter_n;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int LW = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT A: round-robin
    logic [NP-1:0]    req_read_a, req_write_a, req_resp_a;
    logic [NP*AW-1:0] req_address_a;
    logic [NP*LW-1:0] req_wdata_a;
    logic [LW-1:0]    req_rdata_a, mem_wdata_a, mem_rdata_a;
    logic             mem_read_a, mem_write_a, mem_resp_a;
    logic [AW-1:0]    mem_address_a;

    // DUT B: fixed priority, zero-wait memory tied to its own request outputs
    logic [NP-1:0]    req_read_b, req_write_b, req_resp_b;
    logic [NP*AW-1:0] req_address_b;
    logic [NP*LW-1:0] req_wdata_b;
    logic [LW-1:0]    req_rdata_b, mem_wdata_b, mem_rdata_b;
    logic             mem_read_b, mem_write_b, mem_resp_b;
    logic [AW-1:0]    mem_address_b;

    logic          auto_resp, man_resp, mem_auto;
    logic [LW-1:0] auto_rdata, man_rdata;
    int            mem_lat_max, lat;

    assign mem_resp_a  = auto_resp | man_resp;
    assign mem_rdata_a = auto_resp ? auto_rdata : man_rdata;
    assign mem_resp_b  = mem_read_b | mem_write_b;

    mem_arbiter_n #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .req_read(req_read_a), .req_write(req_write_a),
        .req_address(req_address_a), .req_wdata(req_wdata_a),
        .req_resp(req_resp_a), .req_rdata(req_rdata_a),
        .mem_read(mem_read_a), .mem_write(mem_write_a),
        .mem_address(mem_address_a), .mem_wdata(mem_wdata_a),
        .mem_resp(mem_resp_a), .mem_rdata(mem_rdata_a)
    );

    mem_arbiter_n #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .req_read(req_read_b), .req_write(req_write_b),
        .req_address(req_address_b), .req_wdata(req_wdata_b),
        .req_resp(req_resp_b), .req_rdata(req_rdata_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b),
        .mem_address(mem_address_b), .mem_wdata(mem_wdata_b),
        .mem_resp(mem_resp_b), .mem_rdata(mem_rdata_b)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic bit bit_of(input logic [NP-1:0] v, input int i);
        logic [NP-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    // First requesting port scanning upward from start, wrapping.
    function automatic int pick_from(input logic [NP-1:0] r, input int start);
        for (int k = 0; k < NP; k++) begin
            if (bit_of(r, (start + k) % NP)) return (start + k) % NP;
        end
        return -1;
    endfunction

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int            due;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } mem_exp_t;

    typedef struct {
        int            due;
        int            port;
        logic [LW-1:0] rdata;
    } resp_exp_t;

    mem_exp_t  exp_mem_q[$];
    resp_exp_t exp_resp_q[$];
    int        ecount = 0;

    // Transaction-level view: a grant reserves the memory; the pulse follows the mem_resp
    // cycle, and the arbiter can grant again two edges after mem_resp was seen.
    initial begin : model
        int            owner, rr, resp_edge, w;
        logic          own_wr;
        logic [LW-1:0] last_rd;
        mem_exp_t      me;
        resp_exp_t     re;
        owner = -1; rr = 0; resp_edge = -1; own_wr = 1'b0; last_rd = '0;
        forever begin
            @(posedge clk);
            ecount++;
            if (reset) begin
                owner = -1; rr = 0; resp_edge = -1; last_rd = '0;
                exp_mem_q.delete();
                exp_resp_q.delete();
            end else begin
                if (owner >= 0 && resp_edge >= 0 && ecount == resp_edge + 2) owner = -1;
                if (owner < 0) begin
                    w = pick_from(req_read_a | req_write_a, rr);
                    if (w >= 0) begin
                        me.due   = ecount;
                        me.wr    = bit_of(req_write_a, w);
                        me.addr  = req_address_a[w*AW +: AW];
                        me.wdata = req_wdata_a[w*LW +: LW];
                        exp_mem_q.push_back(me);
                        owner = w; own_wr = me.wr; resp_edge = -1;
                        rr = (w + 1) % NP;
                    end
                end else if (resp_edge < 0 && mem_resp_a) begin
                    resp_edge = ecount;
                    if (!own_wr) last_rd = mem_rdata_a;
                    re.due = ecount; re.port = owner; re.rdata = last_rd;
                    exp_resp_q.push_back(re);
                end
            end
        end
    end

    initial begin : monitor
        logic      op, op_prev;
        mem_exp_t  cur;
        resp_exp_t re;
        op_prev = 1'b0;
        cur = '{due: 0, wr: 1'b0, addr: '0, wdata: '0};
        forever begin
            @(negedge clk);
            if (reset) begin
                op_prev = 1'b0;
            end else begin
                op = mem_read_a | mem_write_a;
                if (exp_mem_q.size() > 0 && exp_mem_q[0].due < ecount) begin
                    fail_now("sb_mem_op_missing");
                    void'(exp_mem_q.pop_front());
                end
                if (op && !op_prev) begin
                    if (exp_mem_q.size() == 0) fail_now("sb_mem_op_unexpected");
                    else begin
                        cur = exp_mem_q.pop_front();
                        chk("sb_mem_op_cycle", LW'(ecount), LW'(cur.due));
                    end
                end
                if (op) begin
                    chk("sb_mem_write", LW'(mem_write_a), LW'(cur.wr));
                    chk("sb_mem_read", LW'(mem_read_a), LW'(!cur.wr));
                    chk("sb_mem_address", LW'(mem_address_a), LW'(cur.addr));
                    chk("sb_mem_wdata", mem_wdata_a, cur.wdata);
                end
                if (exp_resp_q.size() > 0 && exp_resp_q[0].due < ecount) begin
                    fail_now("sb_req_resp_missing");
                    void'(exp_resp_q.pop_front());
                end
                if (req_resp_a != '0) begin
                    if (exp_resp_q.size() == 0) fail_now("sb_req_resp_unexpected");
                    else begin
                        re = exp_resp_q.pop_front();
                        chk("sb_resp_cycle", LW'(ecount), LW'(re.due));
                        chk("sb_req_resp", LW'(req_resp_a), LW'(NP'(1) << re.port));
                        chk("sb_req_rdata", req_rdata_a, re.rdata);
                    end
                end
                op_prev = op;
            end
        end
    end

    // ---------------- memory responder for DUT A ----------------
    initial begin : mem_model
        auto_resp = 1'b0; auto_rdata = '0; lat = -1;
        forever begin
            @(posedge clk); #1;
            auto_resp = 1'b0;
            if (mem_auto && (mem_read_a || mem_write_a)) begin
                if (lat < 0) lat = int'($urandom_range(0, mem_lat_max));
                if (lat == 0) begin
                    auto_resp  = 1'b1;
                    auto_rdata = {$urandom, $urandom};
                    lat = -1;
                end else begin
                    lat--;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    bit pend[NP];
    int gap[NP];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_cycle(input bit issue);
        logic [NP-1:0] got;
        int kind;
        @(negedge clk);
        got = req_resp_a;
        @(posedge clk); #1;
        for (int p = 0; p < NP; p++) begin
            if (pend[p]) begin
                if (bit_of(got, p)) begin
                    req_read_a[p] = 1'b0; req_write_a[p] = 1'b0;
                    pend[p] = 1'b0; gap[p] = int'($urandom_range(0, 3));
                end
            end else if (issue) begin
                if (gap[p] == 0) begin
                    kind = int'($urandom_range(0, 2));
                    req_address_a[p*AW +: AW] = AW'($urandom);
                    req_wdata_a[p*LW +: LW]   = {$urandom, $urandom};
                    req_read_a[p]  = (kind != 1);
                    req_write_a[p] = (kind != 0);
                    pend[p] = 1'b1;
                end else begin
                    gap[p]--;
                end
            end
        end
    endtask

    task automatic wait_op(input string name, input int lim);
        int k;
        k = 0;
        @(negedge clk);
        while (!(mem_read_a || mem_write_a) && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(name, LW'(mem_read_a || mem_write_a), LW'(1));
    endtask

    task automatic quiet_check(input string name, input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (req_resp_a != '0 || mem_read_a || mem_write_a) cnt++;
        end
        chk(name, LW'(cnt), LW'(0));
    endtask

    initial begin : main
        int            busy_cnt, k, ngot, bcnt;
        int            order[8];
        logic [NP-1:0] expb;
        reset = 1'b1;
        req_read_a = '0; req_write_a = '0; req_address_a = '0; req_wdata_a = '0;
        req_read_b = '0; req_write_b = '0; req_address_b = '0; req_wdata_b = '0;
        mem_rdata_b = '0;
        man_resp = 1'b0; man_rdata = '0; mem_auto = 1'b1; mem_lat_max = 3;
        for (int p = 0; p < NP; p++) begin pend[p] = 1'b0; gap[p] = p; end

        #12;
        chk("reset_mem_read", LW'(mem_read_a), '0);
        chk("reset_mem_write", LW'(mem_write_a), '0);
        chk("reset_mem_address", LW'(mem_address_a), '0);
        chk("reset_mem_wdata", mem_wdata_a, '0);
        chk("reset_req_resp", LW'(req_resp_a), '0);
        chk("reset_req_rdata", req_rdata_a, '0);
        tick();
        reset = 1'b0;

        // Randomised traffic on all ports, checked by the scoreboard.
        for (int c = 0; c < 600; c++) drive_cycle(1'b1);
        k = 0;
        busy_cnt = 1;
        while (busy_cnt != 0 && k < 300) begin
            drive_cycle(1'b0);
            busy_cnt = 0;
            for (int p = 0; p < NP; p++) if (pend[p]) busy_cnt++;
            k++;
        end
        chk("random_drain", LW'(busy_cnt), '0);
        repeat (4) tick();
        mem_auto = 1'b0;

        // Single read on port 1, response 4 cycles after mem_read rises.
        req_address_a[1*AW +: AW] = 16'h1240;
        req_read_a[1] = 1'b1;
        wait_op("rd_started", 8);
        chk("rd_mem_read", LW'(mem_read_a), LW'(1));
        chk("rd_mem_address", LW'(mem_address_a), LW'(16'h1240));
        repeat (4) tick();
        man_resp = 1'b1; man_rdata = {8{8'hA5}};
        tick();
        man_resp = 1'b0; man_rdata = '0;
        @(negedge clk);
        chk("rd_req_resp", LW'(req_resp_a), LW'(4'b0010));
        chk("rd_req_rdata", req_rdata_a, {8{8'hA5}});
        tick();
        req_read_a[1] = 1'b0;

        // Read+write on port 0 is a single write; read line register keeps A5.
        req_address_a[0*AW +: AW] = 16'h0200;
        req_wdata_a[0*LW +: LW] = {16{4'h1}};
        req_read_a[0] = 1'b1; req_write_a[0] = 1'b1;
        wait_op("wr_started", 8);
        chk("wr_mem_write", LW'(mem_write_a), LW'(1));
        chk("wr_mem_read", LW'(mem_read_a), '0);
        chk("wr_mem_wdata", mem_wdata_a, {16{4'h1}});
        tick();
        man_resp = 1'b1; man_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        man_resp = 1'b0; man_rdata = '0;
        @(negedge clk);
        chk("wr_req_resp", LW'(req_resp_a), LW'(4'b0001));
        chk("wr_req_rdata_kept", req_rdata_a, {8{8'hA5}});
        tick();
        req_read_a[0] = 1'b0; req_write_a[0] = 1'b0;
        quiet_check("wr_single_resp", 4);

        // Inputs changed and request dropped mid-flight; stray mem_resp while idle.
        tick();
        req_address_a[2*AW +: AW] = 16'h0ABC;
        req_read_a[2] = 1'b1;
        wait_op("mid_started", 8);
        tick();
        req_address_a[2*AW +: AW] = 16'h7777;
        req_read_a[2] = 1'b0;
        @(negedge clk);
        chk("mid_mem_address", LW'(mem_address_a), LW'(16'h0ABC));
        chk("mid_mem_read_held", LW'(mem_read_a), LW'(1));
        tick();
        man_resp = 1'b1; man_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        man_resp = 1'b0;
        @(negedge clk);
        chk("mid_req_resp", LW'(req_resp_a), LW'(4'b0100));
        tick();
        man_resp = 1'b1;
        tick();
        man_resp = 1'b0;
        quiet_check("stray_resp_ignored", 4);

        // Reset while BUSY: outputs clear without a clock edge; late mem_resp ignored.
        tick();
        req_address_a[3*AW +: AW] = 16'h3300;
        req_read_a[3] = 1'b1;
        wait_op("rst_started", 8);
        reset = 1'b1;
        #1;
        chk("rst_mem_read", LW'(mem_read_a), '0);
        chk("rst_mem_write", LW'(mem_write_a), '0);
        chk("rst_mem_address", LW'(mem_address_a), '0);
        chk("rst_mem_wdata", mem_wdata_a, '0);
        chk("rst_req_resp", LW'(req_resp_a), '0);
        chk("rst_req_rdata", req_rdata_a, '0);
        tick();
        reset = 1'b0;
        req_read_a[3] = 1'b0;
        tick();
        man_resp = 1'b1;
        tick();
        man_resp = 1'b0;
        quiet_check("rst_late_resp_ignored", 3);
        tick();
        req_address_a[0*AW +: AW] = 16'h0100;
        req_address_a[1*AW +: AW] = 16'h0110;
        req_read_a[0] = 1'b1; req_read_a[1] = 1'b1;
        wait_op("rst_rr_started", 8);
        chk("rst_rr_addr", LW'(mem_address_a), LW'(16'h0100));
        tick();
        man_resp = 1'b1;
        tick();
        man_resp = 1'b0;
        @(negedge clk);
        chk("rst_rr_port0_wins", LW'(req_resp_a), LW'(4'b0001));
        tick();
        req_read_a = '0;
        repeat (2) tick();

        // Round-robin fairness from a fresh reset, all ports requesting, zero-wait memory.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_lat_max = 0; mem_auto = 1'b1;
        for (int p = 0; p < NP; p++) req_address_a[p*AW +: AW] = AW'(16'h4000 + p);
        req_read_a = '1;
        ngot = 0; k = 0;
        while (ngot < 8 && k < 80) begin
            @(negedge clk);
            if (req_resp_a != '0) begin
                order[ngot] = -1;
                for (int p = 0; p < NP; p++) if (bit_of(req_resp_a, p)) order[ngot] = p;
                ngot++;
            end
            k++;
        end
        tick();
        req_read_a = '0;
        chk("rr_grant_count", LW'(ngot), LW'(8));
        for (int i = 0; i < ngot; i++) chk("rr_grant_order", LW'(order[i]), LW'(i % NP));
        repeat (4) tick();
        mem_auto = 1'b0;

        // Fixed priority: ports 0 and 2 request continuously, lowest index always wins.
        req_read_b = 4'b0101;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_resp_b != '0) begin
                expb = NP'(1) << pick_from(req_read_b, 0);
                chk("fixed_grant", LW'(req_resp_b), LW'(expb));
                bcnt++;
            end
        end
        tick();
        req_read_b = '0;
        chk("fixed_enough_grants", LW'(bcnt >= 10), LW'(1));

        repeat (4) tick();
        chk("sb_queues_empty", LW'(exp_mem_q.size() + exp_resp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_n.md
# mem_arbiter_n

Parametrised N-requester memory arbiter between the L1 caches (I, D, and future prefetch/victim ports) and the shared L2 cache-line interface. It generalises the fixed two-port I/D arbiter to NUM_PORTS requesters, configurable address/line widths and a selectable fixed-priority or round-robin grant policy. It registers the winning request and serialises one line transfer at a time downstream. It returns the response with a one-cycle registered pulse to the granted requester only.

## Interface
- NUM_PORTS, 2, number of requesters (2..8); port 0 is highest priority in fixed mode
- ADDR_WIDTH, 16, byte address width
- LINE_WIDTH, 256, cache-line data width
- RR_MODE, 1, 1 = round-robin grant, 0 = fixed priority (lowest index wins)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_read  in  NUM_PORTS  per-port line read request, level, held until req_resp
- req_write  in  NUM_PORTS  per-port line write request, level, held until req_resp
- req_address  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*LINE_WIDTH  per-port write line, same packing
- req_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse
- req_rdata  out  LINE_WIDTH  registered read line, shared by all ports, valid while req_resp is high
- mem_read  out  1  downstream read, held until mem_resp
- mem_write  out  1  downstream write, held until mem_resp
- mem_address  out  ADDR_WIDTH  registered granted address
- mem_wdata  out  LINE_WIDTH  registered granted write line
- mem_resp  in  1  downstream completion, one-cycle pulse
- mem_rdata  in  LINE_WIDTH  downstream read line, valid with mem_resp

## Operation
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - Port i is requesting when req_read[i] | req_write[i].
  - If any port requests, select a winner by policy.
  - Latch into registers: grant index, op (write if req_write set, else read), address, wdata. Go to BUSY.
  - With no requests, stay in IDLE.
- Policy:
  - RR_MODE=0: lowest requesting index wins.
  - RR_MODE=1: search starts at rr_ptr and wraps modulo NUM_PORTS; the first requesting port wins.
  - rr_ptr updates to winner+1 (mod NUM_PORTS) at the grant edge.
- BUSY:
  - Drive mem_read or mem_write (exactly one) plus the latched mem_address and mem_wdata.
  - Hold them until mem_resp. On mem_resp, capture mem_rdata into the rdata register (reads only; writes leave it unchanged) and go to DONE.
- DONE:
  - req_resp[grant] = 1 for exactly this cycle; req_rdata = captured line.
  - mem_read and mem_write are 0. Return to IDLE.
- Request inputs are sampled only in IDLE. Changes to a port's request, address or data while BUSY/DONE have no effect on the transaction in flight.
- A request withdrawn while BUSY still completes and still pulses req_resp.
- A port asserting both req_read and req_write is serviced as a single write with a single req_resp.
- mem_resp in IDLE or DONE is ignored.
- Reset:
  - Asynchronous. State goes to IDLE, rr_ptr = 0, grant = 0.
  - All outputs 0: mem_read, mem_write, mem_address, mem_wdata, req_resp, req_rdata.
  - A downstream transaction in flight is abandoned; its late mem_resp is ignored.

## Timing
- Request seen in IDLE at edge N -> mem_read/mem_write high from cycle N+1.
- mem_resp high in cycle M -> req_resp pulse in cycle M+1 -> IDLE in cycle M+2.
- Earliest next grant is the edge ending cycle M+2. The requester must drop its request on the edge ending the DONE cycle.
- Minimum occupancy is 3 cycles per transaction with zero-wait mem_resp (mem_resp in the first BUSY cycle).
- No combinational path exists from req_* or mem_* inputs to any output; all outputs are registers or decode of registered state.
- Round-robin guarantee: a continuously requesting port waits at most NUM_PORTS-1 transactions.

## Test plan
- Reset behaviour: assert reset mid-BUSY (mem_read=1) -> all outputs 0 the same cycle without a clock edge. A later mem_resp yields no req_resp. rr_ptr = 0 is confirmed when ports 0 and 1 request together next and port 0 wins.
- Single read:
  - Stimulus: NUM_PORTS=2, port 1 req_read with address 0x1240; mem_resp 4 cycles after mem_read rises, mem_rdata = 0xA5..A5.
  - Required: mem_address = 0x1240; req_resp = 2'b10 one cycle after mem_resp; req_rdata = 0xA5..A5 in that cycle.
- Round-robin fairness: NUM_PORTS=4, RR_MODE=1, all four ports request continuously with zero-wait memory -> grant order 0,1,2,3,0. No port is granted twice before every other port is granted once.
- Fixed priority: RR_MODE=0, ports 0 and 2 request continuously -> port 0 is granted every transaction and port 2 never is.
- Write path and conflict:
  - Port 0 asserts req_read and req_write together with wdata = 0x1111..1111.
  - Required: mem_write=1, mem_read=0, mem_wdata = 0x1111..1111, exactly one req_resp, and req_rdata holds its previous value.
- Mid-transaction input changes:
  - While BUSY, the granted port changes req_address and drops its request; a stray mem_resp arrives while IDLE.
  - Required: mem_address is unchanged, the transaction completes with one req_resp, and the stray mem_resp starts no transaction and produces no pulse.
